// File: rtl/conv_pkg.sv
// Shared types and size helpers for the conv layer parameter loader.
// Sizes derive from layer shape, fold factor and beat width.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMMIT_W,
    LOAD_TH,
    COMMIT_TH,
    DONE
  } ld_state_t;

  function automatic int fold_log_f(input int fold);
    return (fold == 1) ? 1 : $clog2(fold);
  endfunction

  function automatic int result_width_f(
    input int maj,
    input int ch_in,
    input int k_s
  );
    return (maj != 0) ? $clog2(ch_in * k_s)
                      : $clog2(ch_in * k_s * k_s);
  endfunction

  function automatic int w_size_f(
    input int ch_in,
    input int k_s,
    input int ch_out,
    input int fold
  );
    return ch_in * k_s * k_s * ((fold == 1) ? 1 : ch_out / fold);
  endfunction

  function automatic int th_size_f(
    input int rw,
    input int ch_out,
    input int fold
  );
    return rw * ((fold == 1) ? 1 : ch_out / fold);
  endfunction

  function automatic int beats_f(input int size, input int sw);
    return (size + sw - 1) / sw;
  endfunction

endpackage

// File: rtl/conv_param_loader_word_assembler.sv
// Beat-to-word assembler: first beat is most significant,
// overflow bits of the first beat fall off the top.
module param_word_assembler
  import conv_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int SW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat,
  input  logic [SW-1:0]    data,
  output logic [WIDTH-1:0] word,
  output logic             last
);

  localparam int BEATS = beats_f(WIDTH, SW);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BW-1:0] cnt;

  assign last = (cnt == BW'(BEATS - 1));

  // Shift each accepted beat in and wrap the counter on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (beat) begin
      word <= WIDTH'({word, data});
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_param_loader.sv
// Streams fold weight then threshold words into the conv layer.
// Build option CONV_PARAM_LOADER_PARITY_EN adds a parity beat per word.
module conv_param_loader
  import conv_pkg::*;
#(
  parameter int Majority_enable = 0,
  parameter int fold            = 1,
  parameter int ch_out          = 64,
  parameter int ch_in           = 64,
  parameter int k_s             = 3,
  parameter int SW              = 16,
  localparam int FOLD_LOG = fold_log_f(fold),
  localparam int RW       = result_width_f(Majority_enable, ch_in, k_s),
  localparam int W_SIZE   = w_size_f(ch_in, k_s, ch_out, fold),
  localparam int TH_SIZE  = th_size_f(RW, ch_out, fold)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SW-1:0]       s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [W_SIZE-1:0]   stream_w,
  output logic                stream_w_en,
  output logic [FOLD_LOG-1:0] stream_w_addr,
  output logic [TH_SIZE-1:0]  stream_th,
  output logic                stream_th_en,
  output logic [FOLD_LOG-1:0] stream_th_addr,
  output logic                busy,
  output logic                done
`ifdef CONV_PARAM_LOADER_PARITY_EN
  ,
  output logic                err
`endif
);

  ld_state_t state, state_nxt;
  logic [FOLD_LOG-1:0] fold_cnt, fold_nxt;
  logic w_beat, th_beat, w_last, th_last;
  logic last_fold, word_done, commit_ok, par_ph;

  assign last_fold = (fold_cnt == FOLD_LOG'(fold - 1));
  assign w_beat  = s_ready & s_valid & (state == LOAD_W) & ~par_ph;
  assign th_beat = s_ready & s_valid & (state == LOAD_TH) & ~par_ph;
  assign stream_w_addr  = stream_w_en ? fold_cnt : '0;
  assign stream_th_addr = stream_th_en ? fold_cnt : '0;

  param_word_assembler #(.WIDTH(W_SIZE), .SW(SW)) u_w (
    .clk   (clk),
    .reset (reset),
    .beat  (w_beat),
    .data  (s_data),
    .word  (stream_w),
    .last  (w_last)
  );

  param_word_assembler #(.WIDTH(TH_SIZE), .SW(SW)) u_th (
    .clk   (clk),
    .reset (reset),
    .beat  (th_beat),
    .data  (s_data),
    .word  (stream_th),
    .last  (th_last)
  );

`ifdef CONV_PARAM_LOADER_PARITY_EN
  logic par_ok;

  assign word_done = s_valid & par_ph;
  assign commit_ok = par_ok;

  // Track the trailing parity beat and latch its check result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_ph <= 1'b0;
      par_ok <= 1'b0;
      err    <= 1'b0;
    end else begin
      if ((w_beat & w_last) | (th_beat & th_last)) begin
        par_ph <= 1'b1;
      end else if (word_done & s_ready) begin
        par_ph <= 1'b0;
        par_ok <= s_data[0] == ((state == LOAD_W) ? ^stream_w
                                                  : ^stream_th);
      end
      if ((state == IDLE) & start) begin
        err <= 1'b0;
      end else if (((state == COMMIT_W) | (state == COMMIT_TH))
                   & ~par_ok) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign par_ph    = 1'b0;
  assign commit_ok = 1'b1;
  assign word_done = s_valid &
                     ((state == LOAD_W) ? w_last : th_last);
`endif

  // State and fold counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fold_cnt <= fold_nxt;
    end
  end

  // Sequencing: weights for every fold, thresholds, then done.
  always_comb begin
    state_nxt    = state;
    fold_nxt     = fold_cnt;
    s_ready      = 1'b0;
    stream_w_en  = 1'b0;
    stream_th_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          fold_nxt  = '0;
        end
      end
      LOAD_W: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (word_done) state_nxt = COMMIT_W;
      end
      COMMIT_W: begin
        busy        = 1'b1;
        stream_w_en = commit_ok;
        if (last_fold) begin
          fold_nxt  = '0;
          state_nxt = LOAD_TH;
        end else begin
          fold_nxt  = fold_cnt + 1'b1;
          state_nxt = LOAD_W;
        end
      end
      LOAD_TH: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (word_done) state_nxt = COMMIT_TH;
      end
      COMMIT_TH: begin
        busy         = 1'b1;
        stream_th_en = commit_ok;
        if (last_fold) begin
          fold_nxt  = '0;
          state_nxt = DONE;
        end else begin
          fold_nxt  = fold_cnt + 1'b1;
          state_nxt = LOAD_TH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_param_loader.sv
// Scoreboard bench for conv_param_loader, fold=2 small layer.
// Honours CONV_PARAM_LOADER_PARITY_EN when defined.
module tb_conv_param_loader;

`ifdef CONV_PARAM_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [35:0] stream_w;
  logic        stream_w_en;
  logic [0:0]  stream_w_addr;
  logic [5:0]  stream_th;
  logic        stream_th_en;
  logic [0:0]  stream_th_addr;
  logic        busy;
  logic        done;
`ifdef CONV_PARAM_LOADER_PARITY_EN
  logic        err;
`endif

  conv_param_loader #(
    .Majority_enable(0), .fold(2), .ch_out(2),
    .ch_in(4), .k_s(3), .SW(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .stream_w       (stream_w),
    .stream_w_en    (stream_w_en),
    .stream_w_addr  (stream_w_addr),
    .stream_th      (stream_th),
    .stream_th_en   (stream_th_en),
    .stream_th_addr (stream_th_addr),
    .busy           (busy),
    .done           (done)
`ifdef CONV_PARAM_LOADER_PARITY_EN
    ,
    .err            (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          addr;
    logic [35:0] data;
  } ev_t;

  ev_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_th_cyc = -100;
  int done_cnt = 0;
  int nbeats = 0;
  logic prev_w_en = 1'b0;
  logic prev_th_en = 1'b0;

  logic [7:0]  wb [2][5] = '{'{8'hAB, 8'h01, 8'h02, 8'h03, 8'h04},
                             '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}};
  logic [7:0]  thb [2]   = '{8'hC5, 8'h2A};
  logic [35:0] wexp [2]  = '{36'hB01020304, 36'h23456789A};
  logic [35:0] thexp [2] = '{36'h05, 36'h2A};
  logic [7:0]  wpar [2]  = '{8'h00, 8'h00};
  logic [7:0]  thpar [2] = '{8'h00, 8'h01};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input int kind, input int addr,
                         input logic [35:0] data, input string nm);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected event addr=%0d", nm, addr);
    end else begin
      e = q.pop_front();
      chk({nm, "_kind"}, 64'(kind), 64'(e.kind));
      chk({nm, "_addr"}, 64'(addr), 64'(e.addr));
      chk({nm, "_data"}, 64'(data), 64'(e.data));
    end
  endtask

  task automatic push(input int kind, input int addr,
                      input logic [35:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (s_valid && s_ready) nbeats <= nbeats + 1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_w_en <= stream_w_en;
    prev_th_en <= stream_th_en;
    if (stream_w_en) begin
      chk("w_commit_ready", 64'(s_ready), 64'd0);
      chk("w_en_width", 64'(prev_w_en), 64'd0);
      pop_chk(0, int'(stream_w_addr), stream_w, "w_commit");
    end
    if (stream_th_en) begin
      chk("th_commit_ready", 64'(s_ready), 64'd0);
      chk("th_en_width", 64'(prev_th_en), 64'd0);
      last_th_cyc <= cyc;
      pop_chk(1, int'(stream_th_addr), 36'(stream_th), "th_commit");
    end
    if (done) begin
      chk("done_after_th", 64'(cyc - last_th_cyc), 64'd1);
      chk("done_busy", 64'(busy), 64'd0);
      done_cnt <= done_cnt + 1;
      pop_chk(2, 0, 36'h0, "done");
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input int gap);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("beat_timeout", 64'(n), 64'd0);
    end else begin
      @(negedge clk);
    end
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("seq_drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_seq(input int gap, input bit bad_par,
                         input bit start_in_th);
    logic [7:0] p;
    do_start();
    for (int f = 0; f < 2; f++) begin
      if (!(bad_par && f == 1)) push(0, f, wexp[f]);
      for (int b = 0; b < 5; b++) send(wb[f][b], gap);
      if (PAR == 1) begin
        p = (bad_par && f == 1) ? ~wpar[f] : wpar[f];
        send(p, gap);
      end
    end
    if (start_in_th) begin
      s_valid = 1'b0;
      @(negedge clk);
      chk("th_load_ready", 64'(s_ready), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int f = 0; f < 2; f++) begin
      push(1, f, thexp[f]);
      if (f == 1) push(2, 0, 36'h0);
      send(thb[f], gap);
      if (PAR == 1) send(thpar[f], gap);
    end
    s_valid = 1'b0;
    drain();
  endtask

  initial begin
    int b0;
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_w_en", 64'(stream_w_en), 64'd0);
    chk("rst_th_en", 64'(stream_th_en), 64'd0);
    chk("rst_w", 64'(stream_w), 64'd0);
    chk("rst_th", 64'(stream_th), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // continuous beats
    b0 = nbeats;
    d0 = done_cnt;
    run_seq(0, 1'b0, 1'b0);
    chk("t1_beats", 64'(nbeats - b0), 64'(12 + 4 * PAR));
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_w_hold", 64'(stream_w), 64'h23456789A);
    chk("t1_th_hold", 64'(stream_th), 64'h2A);

    // gapped beats
    d0 = done_cnt;
    run_seq(3, 1'b0, 1'b0);
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // reset mid-word
    do_start();
    for (int b = 0; b < 3; b++) send(wb[0][b], 0);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t4_s_ready", 64'(s_ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_w_clr", 64'(stream_w), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    run_seq(0, 1'b0, 1'b0);
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

    // start during threshold load
    d0 = done_cnt;
    run_seq(1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("t5_busy_idle", 64'(busy), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

`ifdef CONV_PARAM_LOADER_PARITY_EN
    chk("t6_err_clean", 64'(err), 64'd0);
    d0 = done_cnt;
    run_seq(0, 1'b1, 1'b0);
    chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t6_err_set", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(err), 64'd1);
    do_start();
    chk("t6_err_clr", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif

    chk("final_queue", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
